probe_bank: RTL and testbench

Parametrised multi-channel line probe and tristate driver for the board's serial lines (MISO and similar). Each channel synchronises its raw pad input and mirrors it to a probe output. Each channel also counts line edges and, in drive mode, runs a pad output enable with turnaround guard cycles. It sits between the top-level bidirectional pads and the test/LED logic. The pads themselves are resolved at top level (`pad = pad_oe ? pad_out : 1'bz`).

---
 rtl/probe_pkg.sv | 21 ++
 rtl/probe_channel.sv | 138 +++++++++++++
 rtl/probe_bank.sv | 71 +++++++
 tb/tb_probe_bank.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/probe_pkg.sv
// Shared definitions for the probe_bank line probe: mode encodings, the
// per-channel drive FSM state type and the drive-request qualifier.
package probe_pkg;

    localparam logic [1:0] MODE_PASS   = 2'd0;
    localparam logic [1:0] MODE_FREEZE = 2'd1;
    localparam logic [1:0] MODE_DRIVE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TURN_ON  = 2'd1,
        DRIVE_ST = 2'd2,
        TURN_OFF = 2'd3
    } drive_state_t;

    // A channel request counts only in DRIVE mode; the reserved mode never drives.
    function automatic logic drive_req(input logic [1:0] mode, input logic tx_en);
        return (mode == MODE_DRIVE) && tx_en;
    endfunction

endpackage

// File: rtl/probe_channel.sv
// One probe channel: input synchroniser, frozen-able probe register,
// saturating edge counter and pad drive FSM with turnaround guard cycles.
module probe_channel
    import probe_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int TURN_CYC    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pad_in,
    input  logic [1:0]       mode,
    input  logic             tx_en,
    input  logic             tx_data,
    input  logic             cnt_clr,
    output logic             probe_out,
    output logic             pad_out,
    output logic             pad_oe,
    output logic [CNT_W-1:0] cnt
);

    localparam int TC_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(TURN_CYC - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_d_r;
    logic                   probe_r;
    logic [CNT_W-1:0]       cnt_r;
    drive_state_t           state_r;
    logic [TC_W-1:0]        tc_r;
    logic                   pad_out_r;
    logic                   pad_oe_r;
    logic                   sync_s;
    logic                   edge_s;
    logic                   req_s;

    assign sync_s = sync_r[SYNC_STAGES-1];
    assign edge_s = sync_s ^ sync_d_r;
    assign req_s  = drive_req(mode, tx_en);

    // Synchroniser chain plus the one-cycle delayed copy used for edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r   <= {SYNC_STAGES{1'b0}};
            sync_d_r <= 1'b0;
        end else begin
            sync_r   <= {sync_r[SYNC_STAGES-2:0], pad_in};
            sync_d_r <= sync_s;
        end
    end

    // Probe register tracks the synchronised line except while frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            probe_r <= 1'b0;
        end else if (mode == MODE_FREEZE) begin
            probe_r <= probe_r;
        end else begin
            probe_r <= sync_s;
        end
    end

    // Saturating edge counter; clear wins over a coincident edge.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (edge_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Drive FSM; pad_oe is asserted only in DRIVE_ST and released without guard on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            tc_r      <= {TC_W{1'b0}};
            pad_out_r <= 1'b0;
            pad_oe_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    pad_oe_r <= 1'b0;
                    tc_r     <= {TC_W{1'b0}};
                    if (req_s) begin
                        state_r <= TURN_ON;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                TURN_ON: begin
                    if (!req_s) begin
                        state_r  <= IDLE;
                        pad_oe_r <= 1'b0;
                    end else if (tc_r == TC_LAST) begin
                        state_r   <= DRIVE_ST;
                        pad_oe_r  <= 1'b1;
                        pad_out_r <= tx_data;
                    end else begin
                        tc_r     <= tc_r + TC_W'(1);
                        pad_oe_r <= 1'b0;
                    end
                end
                DRIVE_ST: begin
                    if (!req_s) begin
                        state_r  <= TURN_OFF;
                        tc_r     <= {TC_W{1'b0}};
                        pad_oe_r <= 1'b0;
                    end else begin
                        pad_out_r <= tx_data;
                        pad_oe_r  <= 1'b1;
                    end
                end
                TURN_OFF: begin
                    pad_oe_r <= 1'b0;
                    if (tc_r == TC_LAST) begin
                        state_r <= IDLE;
                    end else begin
                        tc_r <= tc_r + TC_W'(1);
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    tc_r     <= {TC_W{1'b0}};
                    pad_oe_r <= 1'b0;
                end
            endcase
        end
    end

    assign probe_out = probe_r;
    assign pad_out   = pad_out_r;
    assign pad_oe    = pad_oe_r;
    assign cnt       = cnt_r;

endmodule

// File: rtl/probe_bank.sv
// Multi-channel line probe and tristate driver; channels are replicated
// here and the selected edge counter is registered onto edge_cnt.
module probe_bank
    import probe_pkg::*;
#(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int TURN_CYC    = 2,
    localparam int SEL_W      = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH-1:0]    pad_in,
    input  logic [1:0]       mode,
    input  logic [CH-1:0]    tx_en,
    input  logic [CH-1:0]    tx_data,
    input  logic             cnt_clr,
    input  logic [SEL_W-1:0] cnt_sel,
    output logic [CH-1:0]    probe_out,
    output logic [CH-1:0]    pad_out,
    output logic [CH-1:0]    pad_oe,
    output logic [CNT_W-1:0] edge_cnt
);

    logic [CNT_W-1:0] cnt_s [CH];
    logic [CNT_W-1:0] sel_cnt_s;
    logic [CNT_W-1:0] edge_cnt_r;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        probe_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W),
            .TURN_CYC    (TURN_CYC)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .pad_in    (pad_in[i]),
            .mode      (mode),
            .tx_en     (tx_en[i]),
            .tx_data   (tx_data[i]),
            .cnt_clr   (cnt_clr),
            .probe_out (probe_out[i]),
            .pad_out   (pad_out[i]),
            .pad_oe    (pad_oe[i]),
            .cnt       (cnt_s[i])
        );
    end

    // Select a counter; selections beyond the last channel read as zero.
    always_comb begin
        sel_cnt_s = {CNT_W{1'b0}};
        if (32'(cnt_sel) < CH) begin
            sel_cnt_s = cnt_s[cnt_sel];
        end else begin
            sel_cnt_s = {CNT_W{1'b0}};
        end
    end

    // Registered counter readout.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt_r <= {CNT_W{1'b0}};
        end else begin
            edge_cnt_r <= sel_cnt_s;
        end
    end

    assign edge_cnt = edge_cnt_r;

endmodule

// File: tb/tb_probe_bank.sv
// Self-checking bench for probe_bank (CH=4, SYNC_STAGES=2, CNT_W=4, TURN_CYC=2).
module tb_probe_bank;
    import probe_pkg::*;

    localparam int CH = 4;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [CH-1:0]    pad_in;
    logic [1:0]       mode;
    logic [CH-1:0]    tx_en;
    logic [CH-1:0]    tx_data;
    logic             cnt_clr;
    logic [1:0]       cnt_sel;
    logic [CH-1:0]    probe_out;
    logic [CH-1:0]    pad_out;
    logic [CH-1:0]    pad_oe;
    logic [CNT_W-1:0] edge_cnt;

    logic [31:0] sb_q [$];
    logic [31:0] exp_v;
    int n_checks = 0;
    int n_fail = 0;

    probe_bank #(.CH(CH), .SYNC_STAGES(2), .CNT_W(CNT_W), .TURN_CYC(2)) dut (
        .clk(clk), .rst(rst), .pad_in(pad_in), .mode(mode), .tx_en(tx_en),
        .tx_data(tx_data), .cnt_clr(cnt_clr), .cnt_sel(cnt_sel),
        .probe_out(probe_out), .pad_out(pad_out), .pad_oe(pad_oe), .edge_cnt(edge_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        cnt_clr = 1'b1;
        step(1);
        cnt_clr = 1'b0;
        step(2);
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = MODE_DRIVE; pad_in = 4'hF; tx_en = 4'hF; tx_data = 4'hF;
        cnt_clr = 1'b0; cnt_sel = 2'd0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            sb_q.push_back(32'h0);
            exp_v = sb_q.pop_front(); n_checks++;
            if (32'({probe_out, pad_out, pad_oe, edge_cnt}) !== exp_v) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h expected %h", {probe_out, pad_out, pad_oe, edge_cnt}, exp_v);
            end
        end
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step(1);
            sb_q.push_back((i == 3) ? 32'hF : 32'h0);
            exp_v = sb_q.pop_front(); n_checks++;
            if (32'(pad_oe) !== exp_v) begin
                n_fail++;
                $display("FAIL reset_release_oe cycle %0d: got %h expected %h", i, pad_oe, exp_v);
            end
        end
        tx_en = 4'h0; mode = MODE_PASS; pad_in = 4'h0;
        step(8);
        clear_counters();
    endtask

    task automatic test_pass_latency();
        cnt_sel = 2'd0;
        pad_in[0] = 1'b1;
        step(2);
        sb_q.push_back(32'h0);
        exp_v = sb_q.pop_front(); n_checks++;
        if (32'(probe_out[0]) !== exp_v) begin
            n_fail++;
            $display("FAIL pass_early: got %b expected %0h", probe_out[0], exp_v);
        end
        step(1);
        sb_q.push_back(32'h1);
        exp_v = sb_q.pop_front(); n_checks++;
        if (32'(probe_out[0]) !== exp_v) begin
            n_fail++;
            $display("FAIL pass_latency: got %b expected %0h", probe_out[0], exp_v);
        end
        sb_q.push_back(32'h0);
        exp_v = sb_q.pop_front(); n_checks++;
        if (32'(edge_cnt) !== exp_v) begin
            n_fail++;
            $display("FAIL pass_cnt_early: got %0d expected %0d", edge_cnt, exp_v);
        end
        step(1);
        sb_q.push_back(32'h1);
        exp_v = sb_q.pop_front(); n_checks++;
        if (32'(edge_cnt) !== exp_v) begin
            n_fail++;
            $display("FAIL pass_cnt: got %0d expected %0d", edge_cnt, exp_v);
        end
    endtask

    task automatic test_freeze();
        pad_in = 4'hA;
        step(5);
        clear_counters();
        sb_q.push_back(32'hA);
        exp_v = sb_q.pop_front(); n_checks++;
        if (32'(probe_out) !== exp_v) begin
            n_fail++;
            $display("FAIL freeze_setup: got %h expected %h", probe_out, exp_v);
        end
        mode = MODE_FREEZE;
        pad_in = 4'h5; step(2);
        pad_in = 4'hA; step(2);
        pad_in = 4'h5; step(6);
        sb_q.push_back(32'hA);
        exp_v = sb_q.pop_front(); n_checks++;
        if (32'(probe_out) !== exp_v) begin
            n_fail++;
            $display("FAIL freeze_hold: got %h expected %h", probe_out, exp_v);
        end
        for (int ch = 0; ch < CH; ch++) begin
            cnt_sel = 2'(ch);
            sb_q.push_back(32'd3);
            step(1);
            exp_v = sb_q.pop_front(); n_checks++;
            if (32'(edge_cnt) !== exp_v) begin
                n_fail++;
                $display("FAIL freeze_cnt ch%0d: got %0d expected %0d", ch, edge_cnt, exp_v);
            end
        end
        mode = MODE_PASS;
        sb_q.push_back(32'h5);
        step(1);
        exp_v = sb_q.pop_front(); n_checks++;
        if (32'(probe_out) !== exp_v) begin
            n_fail++;
            $display("FAIL freeze_resume: got %h expected %h", probe_out, exp_v);
        end
    endtask

    task automatic test_saturation();
        clear_counters();
        cnt_sel = 2'd2;
        for (int i = 0; i < 20; i++) begin
            pad_in[2] = ~pad_in[2];
            step(2);
        end
        step(4);
        sb_q.push_back(32'd15);
        exp_v = sb_q.pop_front(); n_checks++;
        if (32'(edge_cnt) !== exp_v) begin
            n_fail++;
            $display("FAIL saturate: got %0d expected %0d", edge_cnt, exp_v);
        end
        // Line toggles now; its counted edge lands on the same clock as cnt_clr.
        pad_in[2] = ~pad_in[2];
        step(2);
        cnt_clr = 1'b1;
        step(1);
        cnt_clr = 1'b0;
        sb_q.push_back(32'd0);
        step(1);
        exp_v = sb_q.pop_front(); n_checks++;
        if (32'(edge_cnt) !== exp_v) begin
            n_fail++;
            $display("FAIL clr_priority: got %0d expected %0d", edge_cnt, exp_v);
        end
        sb_q.push_back(32'd0);
        step(3);
        exp_v = sb_q.pop_front(); n_checks++;
        if (32'(edge_cnt) !== exp_v) begin
            n_fail++;
            $display("FAIL clr_stable: got %0d expected %0d", edge_cnt, exp_v);
        end
    endtask

    task automatic test_drive_turnaround();
        int oe_cycles;
        oe_cycles = 0;
        mode = MODE_DRIVE; tx_data = 4'h2; tx_en[1] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            if (pad_oe[1]) oe_cycles++;
            if (i == 2 || i == 3) begin
                sb_q.push_back((i == 3) ? 32'h1 : 32'h0);
                exp_v = sb_q.pop_front(); n_checks++;
                if (32'(pad_oe[1]) !== exp_v) begin
                    n_fail++;
                    $display("FAIL drive_oe_rise cycle %0d: got %b expected %0h", i, pad_oe[1], exp_v);
                end
            end
            if (i == 3) begin
                sb_q.push_back(32'h1);
                exp_v = sb_q.pop_front(); n_checks++;
                if (32'(pad_out[1]) !== exp_v) begin
                    n_fail++;
                    $display("FAIL drive_pad_out: got %b expected %0h", pad_out[1], exp_v);
                end
            end
            if (i == 5) begin
                tx_data[1] = 1'b0;
                sb_q.push_back(32'h0);
            end
            if (i == 6) begin
                exp_v = sb_q.pop_front(); n_checks++;
                if (32'(pad_out[1]) !== exp_v) begin
                    n_fail++;
                    $display("FAIL drive_data_follow: got %b expected %0h", pad_out[1], exp_v);
                end
                tx_data[1] = 1'b1;
            end
        end
        tx_en[1] = 1'b0;
        step(1);
        sb_q.push_back(32'h0);
        exp_v = sb_q.pop_front(); n_checks++;
        if (32'(pad_oe[1]) !== exp_v) begin
            n_fail++;
            $display("FAIL drive_oe_fall: got %b expected %0h", pad_oe[1], exp_v);
        end
        sb_q.push_back(32'd8);
        exp_v = sb_q.pop_front(); n_checks++;
        if (32'(oe_cycles) !== exp_v) begin
            n_fail++;
            $display("FAIL drive_oe_width: got %0d expected %0d", oe_cycles, exp_v);
        end
        // Re-request while TURN_OFF is still running.
        tx_en[1] = 1'b1;
        for (int j = 2; j <= 6; j++) begin
            step(1);
            sb_q.push_back((j == 6) ? 32'h1 : 32'h0);
            exp_v = sb_q.pop_front(); n_checks++;
            if (32'(pad_oe[1]) !== exp_v) begin
                n_fail++;
                $display("FAIL rerequest_oe m+%0d: got %b expected %0h", j, pad_oe[1], exp_v);
            end
        end
        tx_en[1] = 1'b0;
        step(5);
    endtask

    task automatic test_abort();
        logic seen_oe;
        int waited;
        mode = MODE_DRIVE; tx_data[3] = 1'b1; tx_en[3] = 1'b1;
        step(1);
        mode = MODE_PASS;
        seen_oe = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (pad_oe[3]) seen_oe = 1'b1;
        end
        sb_q.push_back(32'h0);
        exp_v = sb_q.pop_front(); n_checks++;
        if (32'(seen_oe) !== exp_v) begin
            n_fail++;
            $display("FAIL abort_turn_on: got %b expected %0h", seen_oe, exp_v);
        end
        mode = MODE_DRIVE;
        waited = 0;
        while (!pad_oe[3] && waited < 10) begin
            step(1);
            waited++;
        end
        sb_q.push_back(32'h1);
        exp_v = sb_q.pop_front(); n_checks++;
        if (32'(pad_oe[3]) !== exp_v) begin
            n_fail++;
            $display("FAIL abort_reacquire timeout: got %b expected %0h", pad_oe[3], exp_v);
        end
        mode = MODE_PASS;
        sb_q.push_back(32'h0);
        step(1);
        exp_v = sb_q.pop_front(); n_checks++;
        if (32'(pad_oe[3]) !== exp_v) begin
            n_fail++;
            $display("FAIL abort_drive_st: got %b expected %0h", pad_oe[3], exp_v);
        end
        tx_en[3] = 1'b0;
        step(4);
    endtask

    initial begin
        test_reset();
        test_pass_latency();
        test_freeze();
        test_saturation();
        test_drive_turnaround();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
